// File: rtl/data_cache_if.sv
// data_cache_if: CPU memory-stage port and backing-memory port of the data cache.
//   cpu_*  : access request from the pipeline; cpu_rdata/cpu_stall returned.
//   mem_*  : single-beat request/ready bus to backing memory.
// Modports: slave = the cache, master = the pipeline/memory environment.
interface data_cache_if #(
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_W = DATA_WIDTH / 8;

  logic                  cpu_req;
  logic                  cpu_we;
  logic                  cpu_addrmode;
  logic [DATA_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_stall;

  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [STRB_W-1:0]     mem_wstrb;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;

  modport slave (
    input  cpu_req, cpu_we, cpu_addrmode, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
    output cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output cpu_req, cpu_we, cpu_addrmode, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
    input  cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache.
//   clk   : rising-edge clock
//   rst   : asynchronous active-low reset
//   bus   : data_cache_if.slave (CPU request/response + backing memory bus)
// Lines are 4 words. Load hits return data combinationally in IDLE; load
// misses refill the whole line (4 beats) and then hit; every store goes to
// memory and updates the array only if the line is already resident.
module data_cache #(
  parameter int DATA_WIDTH = 32,
  parameter int SETS       = 64
) (
  input logic         clk,
  input logic         rst,
  data_cache_if.slave bus
);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = DATA_WIDTH - 4 - IDX_W;
  localparam int STRB_W = DATA_WIDTH / 8;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REFILL = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;

  // Array storage: data and tags are never reset; only valid bits are.
  logic [DATA_WIDTH-1:0] data_mem [SETS*4];
  logic [TAG_W-1:0]      tag_mem  [SETS];

  logic [1:0]            state_q, state_d;
  logic [1:0]            beat_q, beat_d;
  logic [SETS-1:0]       valid_q, valid_d;
  logic [DATA_WIDTH-1:0] lat_addr_q, lat_addr_d;
  logic [DATA_WIDTH-1:0] lat_wdata_q, lat_wdata_d;
  logic                  lat_byte_q, lat_byte_d;

  logic                  arr_we;
  logic [IDX_W+1:0]      arr_widx;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic [STRB_W-1:0]     arr_wstrb;
  logic                  tag_we;

  logic [IDX_W-1:0]      cpu_idx, lat_idx;
  logic [TAG_W-1:0]      cpu_tag, lat_tag;
  logic                  cpu_hit, lat_hit;
  logic [DATA_WIDTH-1:0] cpu_word;

  assign cpu_idx  = bus.cpu_addr[4 +: IDX_W];
  assign cpu_tag  = bus.cpu_addr[DATA_WIDTH-1 -: TAG_W];
  assign lat_idx  = lat_addr_q[4 +: IDX_W];
  assign lat_tag  = lat_addr_q[DATA_WIDTH-1 -: TAG_W];
  assign cpu_hit  = valid_q[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
  assign lat_hit  = valid_q[lat_idx] && (tag_mem[lat_idx] == lat_tag);
  assign cpu_word = data_mem[{cpu_idx, bus.cpu_addr[3:2]}];

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    valid_d       = valid_q;
    lat_addr_d    = lat_addr_q;
    lat_wdata_d   = lat_wdata_q;
    lat_byte_d    = lat_byte_q;
    arr_we        = 1'b0;
    arr_widx      = '0;
    arr_wdata     = '0;
    arr_wstrb     = '0;
    tag_we        = 1'b0;
    bus.cpu_rdata = '0;
    bus.cpu_stall = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.cpu_req) begin
          if (!bus.cpu_we) begin
            if (cpu_hit) begin
              bus.cpu_rdata = bus.cpu_addrmode
                            ? DATA_WIDTH'(cpu_word[{bus.cpu_addr[1:0], 3'b000} +: 8])
                            : cpu_word;
            end else begin
              bus.cpu_stall = 1'b1;
              state_d       = S_REFILL;
              beat_d        = 2'd0;
              lat_addr_d    = bus.cpu_addr;
            end
          end else begin
            bus.cpu_stall = 1'b1;
            state_d       = S_WRITE;
            lat_addr_d    = bus.cpu_addr;
            lat_wdata_d   = bus.cpu_wdata;
            lat_byte_d    = bus.cpu_addrmode;
          end
        end
      end
      S_REFILL: begin
        bus.cpu_stall = bus.cpu_req;
        bus.mem_req   = 1'b1;
        bus.mem_addr  = {lat_tag, lat_idx, beat_q, 2'b00};
        if (bus.mem_ready) begin
          arr_we    = 1'b1;
          arr_widx  = {lat_idx, beat_q};
          arr_wdata = bus.mem_rdata;
          arr_wstrb = '1;
          beat_d    = beat_q + 2'd1;
          // Line becomes valid only once the last beat lands, so an aborted
          // refill never exposes a partial line.
          if (beat_q == 2'd3) begin
            valid_d[lat_idx] = 1'b1;
            tag_we           = 1'b1;
            state_d          = S_IDLE;
          end
        end
      end
      S_WRITE: begin
        bus.cpu_stall = ~bus.mem_ready;
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = {lat_addr_q[DATA_WIDTH-1:2], 2'b00};
        bus.mem_wdata = lat_byte_q ? {STRB_W{lat_wdata_q[7:0]}} : lat_wdata_q;
        bus.mem_wstrb = lat_byte_q ? (STRB_W'(1) << lat_addr_q[1:0]) : '1;
        if (bus.mem_ready) begin
          state_d = S_IDLE;
          // No write-allocate: a store miss leaves the array untouched.
          if (lat_hit) begin
            arr_we    = 1'b1;
            arr_widx  = {lat_idx, lat_addr_q[3:2]};
            arr_wdata = bus.mem_wdata;
            arr_wstrb = bus.mem_wstrb;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      beat_q      <= 2'd0;
      valid_q     <= '0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_byte_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      valid_q     <= valid_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      lat_byte_q  <= lat_byte_d;
    end
  end

  always_ff @(posedge clk) begin
    if (arr_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (arr_wstrb[b]) data_mem[arr_widx][8*b +: 8] <= arr_wdata[8*b +: 8];
      end
    end
    if (tag_we) tag_mem[lat_idx] <= lat_tag;
  end
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: table-driven checks of data_cache against a reference memory,
// with a load-data scoreboard and hand sequences for refill, store and reset.
module tb_data_cache;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_cache_if #(.DATA_WIDTH(32)) bus();
  data_cache #(.DATA_WIDTH(32), .SETS(64)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference backing memory; untouched words hold an address hash.
  logic [31:0] ref_mem [logic [31:0]];
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return (a * 32'h9E3779B1) ^ 32'h0F1E2D3C;
  endfunction

  function automatic logic [31:0] exp_load(input bit byt, input logic [31:0] a);
    logic [31:0] w;
    w = ref_rd({a[31:2], 2'b00});
    if (byt) return (w >> (8 * a[1:0])) & 32'hFF;
    return w;
  endfunction

  // Memory responder: mem_ready after rlat/wlat cycles of mem_req.
  int          rlat = 1, wlat = 1;
  int          n_rd = 0, n_wr = 0;
  logic [31:0] rd_addrs [$];
  logic [31:0] last_waddr, last_wdata;
  logic [3:0]  last_wstrb;

  initial begin
    int          cnt;
    bit          waiting;
    logic [31:0] s_addr, s_wdata, w;
    logic [3:0]  s_wstrb;
    logic        s_we;
    cnt = 0; waiting = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.mem_req) begin
        if (waiting) begin
          check("mem_addr_hold",  bus.mem_addr,  s_addr);
          check("mem_we_hold",    32'(bus.mem_we), 32'(s_we));
          check("mem_wdata_hold", bus.mem_wdata, s_wdata);
          check("mem_wstrb_hold", 32'(bus.mem_wstrb), 32'(s_wstrb));
        end
        cnt++;
        if (cnt >= (bus.mem_we ? wlat : rlat)) begin
          bus.mem_ready = 1'b1;
          cnt = 0; waiting = 0;
          if (bus.mem_we) begin
            w = ref_rd(bus.mem_addr);
            for (int b = 0; b < 4; b++)
              if (bus.mem_wstrb[b]) w[8*b +: 8] = bus.mem_wdata[8*b +: 8];
            ref_mem[bus.mem_addr] = w;
            last_waddr = bus.mem_addr; last_wdata = bus.mem_wdata; last_wstrb = bus.mem_wstrb;
            n_wr++;
          end else begin
            bus.mem_rdata = ref_rd(bus.mem_addr);
            rd_addrs.push_back(bus.mem_addr);
            n_rd++;
          end
        end else begin
          bus.mem_ready = 1'b0;
          waiting = 1;
          s_addr = bus.mem_addr; s_we = bus.mem_we; s_wdata = bus.mem_wdata; s_wstrb = bus.mem_wstrb;
        end
      end else begin
        bus.mem_ready = 1'b0;
        cnt = 0; waiting = 0;
      end
    end
  end

  logic [31:0] exp_q [$];

  // One CPU access, starting just after a rising edge; ends just after the
  // rising edge that retires it.
  task automatic access(input bit we, input bit byt, input logic [31:0] addr,
                        input logic [31:0] wdata, output int stalls);
    logic [31:0] rd, ex;
    bit          tmo;
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addrmode = byt;
    bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    if (!we) exp_q.push_back(exp_load(byt, addr));
    stalls = 0; tmo = 1; rd = '0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!bus.cpu_stall) begin tmo = 0; rd = bus.cpu_rdata; break; end
      stalls++;
    end
    check("access_timeout", 32'(tmo), 32'd0);
    if (!we) begin
      ex = exp_q.pop_front();
      check($sformatf("rdata@%h", addr), rd, ex);
    end
    @(posedge clk); #1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addrmode = 1'b0;
  endtask

  typedef struct {
    bit          we;
    bit          byt;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          rl;
    int          wl;
    int          exp_stall;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  task automatic run_vec(input vec_t v, input int id);
    int st, r0, w0;
    rlat = v.rl; wlat = v.wl;
    r0 = n_rd; w0 = n_wr;
    access(v.we, v.byt, v.addr, v.wdata, st);
    check($sformatf("v%0d_stall", id), 32'(st), 32'(v.exp_stall));
    check($sformatf("v%0d_rd", id), 32'(n_rd - r0), 32'(v.exp_rd));
    check($sformatf("v%0d_wr", id), 32'(n_wr - w0), 32'(v.exp_wr));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl [14];
    int   st, r0;
    bit   hit_beat;
    tbl[0]  = '{0, 0, 32'h0000_1008, 32'h0,         1, 1, 0, 0, 0};
    tbl[1]  = '{0, 1, 32'h0000_1005, 32'h0,         1, 1, 0, 0, 0};
    tbl[2]  = '{0, 1, 32'h0000_1007, 32'h0,         1, 1, 0, 0, 0};
    tbl[3]  = '{1, 0, 32'h0000_1008, 32'hDEADBEEF,  1, 1, 1, 0, 1};
    tbl[4]  = '{0, 0, 32'h0000_1008, 32'h0,         1, 1, 0, 0, 0};
    tbl[5]  = '{1, 1, 32'h0000_100E, 32'h0000_005A, 1, 2, 2, 0, 1};
    tbl[6]  = '{0, 0, 32'h0000_100C, 32'h0,         1, 1, 0, 0, 0};
    tbl[7]  = '{0, 0, 32'h0000_1400, 32'h0,         2, 1, 9, 4, 0};
    tbl[8]  = '{0, 0, 32'h0000_1000, 32'h0,         2, 1, 9, 4, 0};
    tbl[9]  = '{0, 0, 32'h0000_1008, 32'h0,         1, 1, 0, 0, 0};
    tbl[10] = '{1, 0, 32'h0000_2000, 32'h1234_5678, 1, 1, 1, 0, 1};
    tbl[11] = '{0, 0, 32'h0000_2000, 32'h0,         1, 1, 5, 4, 0};
    tbl[12] = '{0, 0, 32'h0000_2004, 32'h0,         1, 1, 0, 0, 0};
    tbl[13] = '{0, 1, 32'h0000_2003, 32'h0,         1, 1, 0, 0, 0};

    rst = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addrmode = 1'b0;
    bus.cpu_addr = '0; bus.cpu_wdata = '0;
    #22;
    check("rst_mem_req",   32'(bus.mem_req),   32'd0);
    check("rst_mem_we",    32'(bus.mem_we),    32'd0);
    check("rst_cpu_stall", 32'(bus.cpu_stall), 32'd0);
    check("rst_cpu_rdata", bus.cpu_rdata,      32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Cold line fill: 4 sequential beats, 5 stall cycles.
    rlat = 1; rd_addrs.delete(); r0 = n_rd;
    access(0, 0, 32'h0000_1004, 32'h0, st);
    check("cold_stall", 32'(st), 32'd5);
    check("cold_beats", 32'(n_rd - r0), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("cold_beat%0d_addr", i),
            (i < rd_addrs.size()) ? rd_addrs[i] : 32'hFFFF_FFFF, 32'h0000_1000 + 32'(4*i));

    // Byte store to resident line with 3-cycle memory latency.
    wlat = 3; r0 = n_wr;
    access(1, 1, 32'h0000_1005, 32'h0000_00AB, st);
    check("bst_stall", 32'(st), 32'd3);
    check("bst_writes", 32'(n_wr - r0), 32'd1);
    check("bst_addr",  last_waddr, 32'h0000_1004);
    check("bst_wstrb", 32'(last_wstrb), 32'h2);
    check("bst_wdata", last_wdata, 32'hABABABAB);

    for (int i = 0; i < 14; i++) run_vec(tbl[i], i);

    // Idle with no request never stalls.
    @(negedge clk);
    check("idle_stall", 32'(bus.cpu_stall), 32'd0);
    check("idle_rdata", bus.cpu_rdata, 32'd0);
    @(posedge clk); #1;

    // Reset during refill beat 2 aborts the fill.
    rlat = 1; r0 = n_rd; hit_beat = 0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addrmode = 1'b0; bus.cpu_addr = 32'h0000_3000;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (n_rd - r0 >= 3) begin hit_beat = 1; break; end
    end
    check("rst_beat2_reached", 32'(hit_beat), 32'd1);
    rst = 1'b0;
    #1;
    check("rst_mid_mem_req", 32'(bus.mem_req), 32'd0);
    bus.cpu_req = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_no_more_beats", 32'(n_rd - r0), 32'd3);
    r0 = n_rd;
    access(0, 0, 32'h0000_3000, 32'h0, st);
    check("post_rst_stall", 32'(st), 32'd5);
    check("post_rst_beats", 32'(n_rd - r0), 32'd4);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data and address width.
REQ-002 Parameter SETS, default 64, number of direct-mapped lines (power of 2); line = 4 words (16 bytes).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 cpu_req  in  1  memory-stage access valid.
REQ-006 cpu_we  in  1  1 = store, 0 = load.
REQ-007 cpu_addrmode  in  1  0 = word, 1 = byte.
REQ-008 cpu_addr  in  32  byte address: offset [3:2] word, [1:0] byte, index next log2(SETS) bits, tag the rest.
REQ-009 cpu_wdata  in  32  store data; byte store uses [7:0].
REQ-010 cpu_rdata  out  32  load data; byte load zero-extended.
REQ-011 cpu_stall  out  1  hold pipeline while high.
REQ-012 mem_req  out  1  backing-memory request.
REQ-013 mem_we  out  1  backing-memory write.
REQ-014 mem_addr  out  32  word-aligned backing address.
REQ-015 mem_wdata  out  32  write data, byte replicated in all lanes for byte store.
REQ-016 mem_wstrb  out  4  byte lane enables; 4'hF for word.
REQ-017 mem_rdata  in  32  read data, valid when mem_ready.
REQ-018 mem_ready  in  1  completes current beat when mem_req high; ignored otherwise.

Function
REQ-019 Policy: direct-mapped, write-through, no-write-allocate; per-line valid bit, tag, 4 data words.
REQ-020 FSM states IDLE, REFILL, WRITE.
REQ-021 hit = valid[index] & tag match; evaluated combinationally in IDLE.
REQ-022 IDLE, cpu_req & ~cpu_we & hit: cpu_rdata from array same cycle, cpu_stall 0, zero latency.
REQ-023 IDLE, cpu_req & ~cpu_we & ~hit: cpu_stall 1 same cycle; next state REFILL, beat counter 0, latch tag/index.
REQ-024 REFILL: mem_req 1, mem_we 0, mem_addr = {tag, index, beat, 2'b00}; each mem_ready writes mem_rdata to word[beat], beat increments; beat 3 ready sets valid and tag, returns to IDLE.
REQ-025 After refill, IDLE re-evaluates and the held load hits; total load-miss stall = sum of 4 beat latencies + 1 cycle.
REQ-026 IDLE, cpu_req & cpu_we: cpu_stall 1; next state WRITE, latch addr/data/mode.
REQ-027 WRITE: mem_req 1, mem_we 1, mem_addr = {addr[31:2], 2'b00}, mem_wstrb = 4'hF (word) or one-hot of addr[1:0] (byte); cpu_stall = ~mem_ready; on mem_ready, if line hits, array word updated under mem_wstrb; return to IDLE.
REQ-028 Store miss: no allocation, valid bits unchanged.
REQ-029 cpu_stall = cpu_req & ~(IDLE & ~cpu_we & hit) except WRITE per REQ-027; never high when cpu_req low in IDLE.
REQ-030 cpu_req dropping mid-REFILL or mid-WRITE: transaction completes; cpu inputs not resampled until IDLE.
REQ-031 mem_req, mem_addr, mem_we, mem_wdata, mem_wstrb stable while mem_req high and mem_ready low.
REQ-032 Word access ignores addr[1:0]; byte load selects lane addr[1:0].
REQ-033 Conflict refill replaces the line unconditionally (no dirty state).
REQ-034 cpu_rdata 0 when not a hit in IDLE.

Reset
REQ-035 rst low, asynchronously: state IDLE, all valid 0, beat 0, mem_req 0, mem_we 0, cpu_stall 0 (when cpu_req low); array data not cleared.
REQ-036 Reset mid-REFILL/WRITE: partial line discarded (valid stays 0), no further mem beats.

Verification
REQ-037 Cold load 0x0000_1004, memory ready 1 cycle/beat -> 4 beats 0x1000..0x100C, stall 5 cycles, then rdata = mem[0x1004], stall 0.
REQ-038 Load 0x1008 after REQ-037 -> hit, stall 0, no mem_req.
REQ-039 Byte store 0xAB to 0x1005 (line resident), ready after 3 cycles -> mem_wstrb 4'b0010, wdata 0xABABABAB, stall 3 cycles; reload 0x1005 byte -> 0x000000AB with no refill.
REQ-040 Load 0x1000 + SETS*16 (same index) -> refill evicts; subsequent 0x1000 load misses again.
REQ-041 Store miss to 0x2000 -> one mem write, following load 0x2000 misses and refills.
REQ-042 rst low during beat 2 of refill -> mem_req 0 immediately; after release same load misses and refills all 4 beats.
